alu_arbiter: RTL and testbench

Shares the single combinational ALU (32-bit operands, 4-bit operation code, `out`/`negative`/`zero` results) between two requesters, e.g. the main execute path and an address/branch helper unit. Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin between the requesters. Drives the ALU from registered operands and registers the ALU results. Returns them through a single response channel tagged with the requester id.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. An operation is
//   accepted through a valid/ready handshake, with round-robin arbitration
//   when both requesters are valid. The accepted operands drive the ALU from
//   registers. The ALU result is registered one cycle later. The result is
//   returned on a single response channel tagged with the requester id.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid / reqN_ready       requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op       requester N operands and operation
//   alu_in1, alu_in2, alu_op      registered operands/operation to the ALU
//   alu_out, alu_negative,        ALU result and flags
//   alu_zero
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that issued the response
//   rsp_out, rsp_negative,        captured ALU result and flags
//   rsp_zero
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_negative,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Requester that wins when both are valid; points at the one not served last.
  logic prio;
  logic any_valid;
  logic grant;
  logic accept;

  // A lone requester wins outright; on contention the pointer decides.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else begin
      grant = req1_valid;
    end
    accept = (state == IDLE) && any_valid;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: readies depend only on state and request valids, never on
  // rsp_ready, so no combinational path runs from consumer to requesters.
  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    rsp_valid  = (state == RESP);
  end

  // Stage p0 -> p1: operands of the accepted request drive the ALU.
  // Stage p1 -> p2: ALU result captured during EXEC, held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio         <= 1'b0;
      alu_in1      <= '0;
      alu_in2      <= '0;
      alu_op       <= '0;
      rsp_id       <= 1'b0;
      rsp_out      <= '0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (accept) begin
        alu_in1 <= grant ? req1_a  : req0_a;
        alu_in2 <= grant ? req1_b  : req0_b;
        alu_op  <= grant ? req1_op : req0_op;
        rsp_id  <= grant;
        prio    <= ~grant;
      end
      if (state == EXEC) begin
        rsp_out      <= alu_out;
        rsp_negative <= alu_negative;
        rsp_zero     <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter with a behavioural ALU placed behind the block.
//   Each scenario task drives stimulus and checks outputs inline; a final
//   randomized run compares against a transaction-level model.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
  logic [OP_W-1:0]   alu_op;
  logic              alu_negative, alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_negative, rsp_zero;
  logic [DATA_W-1:0] rsp_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {negative, zero, out}.
  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
  function automatic logic [DATA_W+1:0] alu_eval(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0] op);
    logic [DATA_W-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    r = (a < b) ? 32'd1 : 32'd0;
      default: r = b;
    endcase
    return {r[DATA_W-1], (r == '0), r};
  endfunction

  assign {alu_negative, alu_zero, alu_out} = alu_eval(alu_in1, alu_in2, alu_op);

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse away from clock edges; ends at drive time.
  task automatic pulse_reset;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    total++; if ({rsp_negative, rsp_zero, rsp_out} !== '0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp_negative, rsp_zero, rsp_out}); end
    total++; if ({alu_in1, alu_in2, alu_op} !== '0) begin bad++; $display("FAIL reset_alu_regs: got %h want 0", {alu_in1, alu_in2, alu_op}); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [DATA_W+1:0] exp;
    exp = alu_eval(32'd15, 32'd42, 4'd1);
    req0_a = 32'd15; req0_b = 32'd42; req0_op = 4'd1; req0_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if ({alu_in1, alu_in2, alu_op} !== {32'd15, 32'd42, 4'd1}) begin bad++; $display("FAIL single_alu_in: got %h want %h", {alu_in1, alu_in2, alu_op}, {32'd15, 32'd42, 4'd1}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    total++; if ({rsp_valid, rsp_id} !== 2'b10) begin bad++; $display("FAIL single_rsp_vid: got %b want 10", {rsp_valid, rsp_id}); end
    total++; if ({rsp_negative, rsp_zero, rsp_out} !== exp) begin bad++; $display("FAIL single_rsp_data: got %h want %h", {rsp_negative, rsp_zero, rsp_out}, exp); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_done: got %b want 0", rsp_valid); end
  endtask

  task automatic test_simultaneous;
    int gc[$]; int gi[$]; int rc[$]; int ri[$];
    logic [DATA_W+1:0] rv[$];
    logic [DATA_W+1:0] exp[2];
    int nboth;
    pulse_reset;
    exp[0] = alu_eval(32'd7, 32'hFFFF_FFFD, 4'd8);
    exp[1] = alu_eval(32'd7, 32'd8, 4'd9);
    req0_a = 32'd7; req0_b = 32'hFFFF_FFFD; req0_op = 4'd8;
    req1_a = 32'd7; req1_b = 32'd8;         req1_op = 4'd9;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    nboth = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) nboth++;
      if (req0_ready) begin gc.push_back(c); gi.push_back(0); end
      if (req1_ready) begin gc.push_back(c); gi.push_back(1); end
      if (rsp_valid) begin rc.push_back(c); ri.push_back(int'(rsp_id)); rv.push_back({rsp_negative, rsp_zero, rsp_out}); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (nboth != 0) begin bad++; $display("FAIL sim_both_ready: got %0d cycles want 0", nboth); end
    total++; if (gc.size() != 4) begin bad++; $display("FAIL sim_grant_count: got %0d want 4", gc.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= gc.size() || gc[i] != 3 * i || gi[i] != i % 2) begin
        bad++; $display("FAIL sim_grant%0d: got cyc %0d id %0d want cyc %0d id %0d", i,
                        (i < gc.size()) ? gc[i] : -1, (i < gi.size()) ? gi[i] : -1, 3 * i, i % 2);
      end
      total++;
      if (i >= rc.size() || rc[i] != 3 * i + 2 || ri[i] != i % 2 || rv[i] !== exp[i % 2]) begin
        bad++; $display("FAIL sim_rsp%0d: got cyc %0d id %0d data %h want cyc %0d id %0d data %h", i,
                        (i < rc.size()) ? rc[i] : -1, (i < ri.size()) ? ri[i] : -1,
                        (i < rv.size()) ? rv[i] : '0, 3 * i + 2, i % 2, exp[i % 2]);
      end
    end
  endtask

  task automatic test_lone;
    logic [DATA_W+1:0] exp;
    pulse_reset;
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 9));
    exp = alu_eval(req1_a, req1_b, req1_op);
    req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL lone_ready: got %b want 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({rsp_valid, rsp_id, rsp_negative, rsp_zero, rsp_out} !== {2'b11, exp}) begin
      bad++; $display("FAIL lone_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_negative, rsp_zero, rsp_out}, {2'b11, exp}); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL lone_prio_after: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_back_pressure;
    logic [DATA_W+1:0] exp;
    logic [DATA_W-1:0] sa;
    pulse_reset;
    rsp_ready = 1'b0;
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 9));
    sa = req1_a;
    exp = alu_eval(req1_a, req1_b, req1_op);
    req1_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = $urandom; req1_a = $urandom; req1_op = 4'($urandom);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if ({rsp_valid, rsp_id, rsp_negative, rsp_zero, rsp_out} !== {2'b11, exp}) begin
        bad++; $display("FAIL bp_rsp%0d: got %h want %h", k, {rsp_valid, rsp_id, rsp_negative, rsp_zero, rsp_out}, {2'b11, exp}); end
      total++; if ({req0_ready, req1_ready} !== 2'b00 || alu_in1 !== sa) begin
        bad++; $display("FAIL bp_hold%0d: got ready %b in1 %h want ready 00 in1 %h", k, {req0_ready, req1_ready}, alu_in1, sa); end
      @(posedge clk); #1;
      req0_a = $urandom; req1_a = $urandom; req0_b = $urandom; req1_b = $urandom;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
      bad++; $display("FAIL bp_after: got %b want 010", {rsp_valid, req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_zero_and_reset;
    logic [DATA_W+1:0] exp;
    pulse_reset;
    exp = alu_eval(32'd32, 32'd32, 4'd1);
    rsp_ready = 1'b0;
    req0_a = 32'd32; req0_b = 32'd32; req0_op = 4'd1; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_negative, rsp_zero, rsp_out} !== {1'b1, exp}) begin
      bad++; $display("FAIL zero_rsp: got %h want %h", {rsp_valid, rsp_negative, rsp_zero, rsp_out}, {1'b1, exp}); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({rsp_valid, rsp_zero, alu_in1} !== '0) begin
      bad++; $display("FAIL midreset_clear: got %h want 0", {rsp_valid, rsp_zero, alu_in1}); end
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_dropped: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL midreset_prio: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_cycles(2);
  endtask

  // Transaction-level model: one outstanding operation at a time; its
  // response is visible from two cycles after acceptance until taken.
  task automatic test_random(input int n);
    bit m_busy, m_prio, m_id, g, any, exp_rv;
    int m_acc;
    logic [DATA_W-1:0] m_a, m_b;
    logic [OP_W-1:0] m_op;
    pulse_reset;
    m_busy = 0; m_prio = 0; m_acc = 0; m_id = 0; m_a = 0; m_b = 0; m_op = 0;
    for (int cyc = 0; cyc < n; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rv = m_busy && (cyc >= m_acc + 2);
      any = req0_valid | req1_valid;
      g = (req0_valid && req1_valid) ? m_prio : req1_valid;
      total++; if ({req0_ready, req1_ready, rsp_valid} !== {!m_busy && any && !g, !m_busy && any && g, exp_rv}) begin
        bad++; $display("FAIL rand_ctrl c%0d: got %b want %b", cyc, {req0_ready, req1_ready, rsp_valid},
                        {!m_busy && any && !g, !m_busy && any && g, exp_rv}); end
      if (exp_rv) begin
        total++; if ({rsp_id, rsp_negative, rsp_zero, rsp_out} !== {m_id, alu_eval(m_a, m_b, m_op)}) begin
          bad++; $display("FAIL rand_rsp c%0d: got %h want %h", cyc, {rsp_id, rsp_negative, rsp_zero, rsp_out}, {m_id, alu_eval(m_a, m_b, m_op)}); end
      end
      if (m_busy) begin
        total++; if ({alu_in1, alu_in2, alu_op} !== {m_a, m_b, m_op}) begin
          bad++; $display("FAIL rand_alu_in c%0d: got %h want %h", cyc, {alu_in1, alu_in2, alu_op}, {m_a, m_b, m_op}); end
      end
      if (exp_rv && rsp_ready) begin
        m_busy = 0;
      end else if (!m_busy && any) begin
        m_busy = 1; m_acc = cyc; m_id = g; m_prio = !g;
        m_a = g ? req1_a : req0_a; m_b = g ? req1_b : req0_b; m_op = g ? req1_op : req0_op;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_lone;
    test_back_pressure;
    test_zero_and_reset;
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
